// File: rtl/skintone_pkg.sv
// Shared widths, payload type and helpers for the skintone result path.
package skintone_pkg;
  localparam int PIXEL_W          = 24;
  localparam int RESULT_W         = 8;
  localparam int PACKED_W         = 32;
  localparam int KEEP_W           = 4;
  localparam int DATAPATH_LATENCY = 16;

  // Free entries needed to absorb every result already in the datapath
  // (four per word) plus one partially filled word.
  localparam int DEFAULT_ADMIT_THRESH = DATAPATH_LATENCY / 4 + 1;

  // 37-bit FIFO payload: data, keep, last.
  typedef struct packed {
    logic [PACKED_W-1:0] data;
    logic [KEEP_W-1:0]   keep;
    logic                last;
  } packed_word_t;

  // Keep mask covering lanes 0..idx inclusive.
  function automatic logic [KEEP_W-1:0] keep_mask(input logic [1:0] idx);
    logic [KEEP_W:0] m;
    m = (5'd2 << idx) - 5'd1;
    return m[KEEP_W-1:0];
  endfunction
endpackage

// File: rtl/skintone_result_packer_if.sv
// Result input stream and packed output stream of the result packer.
interface skintone_result_packer_if;
  import skintone_pkg::*;

  logic [RESULT_W-1:0] result_datain;
  logic                result_datain_valid;
  logic                result_datain_last;
  logic                pack_ready;
  logic [PACKED_W-1:0] packed_dataout;
  logic [KEEP_W-1:0]   packed_dataout_keep;
  logic                packed_dataout_last;
  logic                packed_dataout_valid;
  logic                packed_dataout_ready;
  logic                overflow_err;

  // Environment side: feeds results, consumes packed words.
  modport master (
    output result_datain, result_datain_valid, result_datain_last,
           packed_dataout_ready,
    input  pack_ready, packed_dataout, packed_dataout_keep,
           packed_dataout_last, packed_dataout_valid, overflow_err
  );

  // Packer side.
  modport slave (
    input  result_datain, result_datain_valid, result_datain_last,
           packed_dataout_ready,
    output pack_ready, packed_dataout, packed_dataout_keep,
           packed_dataout_last, packed_dataout_valid, overflow_err
  );
endinterface

// File: rtl/skintone_word_fifo.sv
// Synchronous FIFO of packed words. A push into a full FIFO is accepted
// only when a pop happens on the same edge; otherwise it is ignored.
module skintone_word_fifo
  import skintone_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  packed_word_t wdata_i,
  output packed_word_t rdata_o,
  output logic [AW:0]  count_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  packed_word_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage write; contents need no reset since empty gates the output.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers and occupancy; pointers wrap naturally at power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/skintone_result_packer.sv
// Packs 8-bit skintone results into 32-bit words, queues them in a FIFO,
// and throttles upstream admission on free FIFO space.
module skintone_result_packer
  import skintone_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int ADMIT_THRESH = DEFAULT_ADMIT_THRESH
) (
  input  logic                     clk,
  input  logic                     rst,
  skintone_result_packer_if.slave  bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [PACKED_W-1:0] partial_q, partial_d;
  logic                ovf_q, ovf_d;
  logic [PACKED_W-1:0] lane_data;
  packed_word_t        push_word, head;
  logic                push, pop, full, empty;
  logic [CW-1:0]       count, free;

  skintone_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_word),
    .rdata_o (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // Lane placement and push decision for the incoming byte.
  always_comb begin
    byte_idx_d = byte_idx_q;
    partial_d  = partial_q;
    push       = 1'b0;
    push_word  = '0;
    lane_data  = partial_q;
    lane_data[{byte_idx_q, 3'b000} +: RESULT_W] = bus.result_datain;
    if (bus.result_datain_valid) begin
      if (byte_idx_q == 2'd3 || bus.result_datain_last) begin
        push           = 1'b1;
        push_word.data = lane_data;
        push_word.keep = keep_mask(byte_idx_q);
        push_word.last = bus.result_datain_last;
        partial_d      = '0;
        byte_idx_d     = '0;
      end else begin
        partial_d  = lane_data;
        byte_idx_d = byte_idx_q + 2'd1;
      end
    end
  end

  assign pop   = !empty && bus.packed_dataout_ready;
  assign ovf_d = ovf_q | (push && full && !pop);
  assign free  = CW'(FIFO_DEPTH) - count;

  assign bus.pack_ready           = (free >= CW'(ADMIT_THRESH));
  assign bus.packed_dataout_valid = !empty;
  assign bus.packed_dataout       = empty ? '0 : head.data;
  assign bus.packed_dataout_keep  = empty ? '0 : head.keep;
  assign bus.packed_dataout_last  = empty ? 1'b0 : head.last;
  assign bus.overflow_err         = ovf_q;

  // Partial-word, lane index and sticky overflow state.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx_q <= '0;
      partial_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      byte_idx_q <= byte_idx_d;
      partial_q  <= partial_d;
      ovf_q      <= ovf_d;
    end
  end
endmodule

// File: tb/tb_skintone_result_packer.sv
// Directed bench for the skintone result packer.
module tb_skintone_result_packer;
  import skintone_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  packed_word_t got[$];

  skintone_result_packer_if bus ();

  skintone_result_packer dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Capture every word the consumer takes (handshake seen mid-cycle).
  always @(negedge clk) begin
    if (bus.packed_dataout_valid && bus.packed_dataout_ready)
      got.push_back('{data: bus.packed_dataout, keep: bus.packed_dataout_keep,
                      last: bus.packed_dataout_last});
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    bus.result_datain       = d;
    bus.result_datain_valid = 1'b1;
    bus.result_datain_last  = l;
    step();
    bus.result_datain_valid = 1'b0;
    bus.result_datain_last  = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] b);
    for (int i = 0; i < 4; i++) send_byte(b + 8'(i), 1'b0);
  endtask

  function automatic packed_word_t mk(input logic [31:0] d, input logic [3:0] k, input logic l);
    return '{data: d, keep: k, last: l};
  endfunction

  function automatic logic [31:0] wd(input logic [7:0] b);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic chk_q(input string tag, input int idx, input packed_word_t exp);
    if (idx < got.size()) chk(tag, 64'(got[idx]), 64'(exp));
    else chk({tag, "_missing"}, 64'(got.size()), 64'(idx + 1));
  endtask

  initial begin
    bus.result_datain        = '0;
    bus.result_datain_valid  = 1'b0;
    bus.result_datain_last   = 1'b0;
    bus.packed_dataout_ready = 1'b0;

    // Reset state
    step(2);
    rst = 1'b0;
    step();
    chk("rst_valid", 64'(bus.packed_dataout_valid), 64'd0);
    chk("rst_keep",  64'(bus.packed_dataout_keep),  64'd0);
    chk("rst_last",  64'(bus.packed_dataout_last),  64'd0);
    chk("rst_data",  64'(bus.packed_dataout),       64'd0);
    chk("rst_ovf",   64'(bus.overflow_err),         64'd0);
    chk("rst_prdy",  64'(bus.pack_ready),           64'd1);

    // Eight bytes, consumer always ready
    bus.packed_dataout_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
    step(3);
    chk("seq_cnt", 64'(got.size()), 64'd2);
    chk_q("seq_w0", 0, mk(32'h04030201, 4'hF, 1'b0));
    chk_q("seq_w1", 1, mk(32'h08070605, 4'hF, 1'b0));

    // Short frame end, then a lone byte closing another frame
    got.delete();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    step(3);
    chk("last_cnt", 64'(got.size()), 64'd2);
    chk_q("last_w0", 0, mk(32'h0000BBAA, 4'h3, 1'b1));
    chk_q("last_w1", 1, mk(32'h000000CC, 4'h1, 1'b1));

    // Admission threshold around occupancy 4
    got.delete();
    bus.packed_dataout_ready = 1'b0;
    for (int k = 0; k < 3; k++) send_word(8'h10 + 8'(4 * k));
    chk("adm_occ3", 64'(bus.pack_ready), 64'd1);
    send_word(8'h1C);
    chk("adm_occ4", 64'(bus.pack_ready), 64'd0);
    chk("adm_hold", 64'(bus.packed_dataout), 64'(wd(8'h10)));
    bus.packed_dataout_ready = 1'b1;
    step();
    bus.packed_dataout_ready = 1'b0;
    chk("adm_back3", 64'(bus.pack_ready), 64'd1);
    bus.packed_dataout_ready = 1'b1;
    step(5);
    chk("adm_cnt", 64'(got.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      chk_q("adm_w", k, mk(wd(8'h10 + 8'(4 * k)), 4'hF, 1'b0));

    // Overflow: nine words into an eight-deep FIFO
    got.delete();
    bus.packed_dataout_ready = 1'b0;
    for (int k = 0; k < 9; k++) send_word(8'h40 + 8'(4 * k));
    chk("ovf_flag", 64'(bus.overflow_err), 64'd1);
    bus.packed_dataout_ready = 1'b1;
    step(10);
    chk("ovf_cnt", 64'(got.size()), 64'd8);
    for (int k = 0; k < 8; k++)
      chk_q("ovf_w", k, mk(wd(8'h40 + 8'(4 * k)), 4'hF, 1'b0));
    chk("ovf_sticky", 64'(bus.overflow_err), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("ovf_clr", 64'(bus.overflow_err), 64'd0);

    // Push and pop on the same edge while full
    got.delete();
    bus.packed_dataout_ready = 1'b0;
    for (int k = 0; k < 8; k++) send_word(8'h80 + 8'(4 * k));
    send_byte(8'hA0, 1'b0);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    bus.packed_dataout_ready = 1'b1;
    send_byte(8'hA3, 1'b0);
    bus.packed_dataout_ready = 1'b0;
    chk("full_ovf",  64'(bus.overflow_err), 64'd0);
    chk("full_prdy", 64'(bus.pack_ready),   64'd0);
    bus.packed_dataout_ready = 1'b1;
    step(11);
    chk("full_cnt", 64'(got.size()), 64'd9);
    for (int k = 0; k < 9; k++)
      chk_q("full_w", k, mk(wd(8'h80 + 8'(4 * k)), 4'hF, 1'b0));

    // Mid-word reset discards everything
    got.delete();
    bus.packed_dataout_ready = 1'b0;
    for (int k = 0; k < 3; k++) send_word(8'h20 + 8'(4 * k));
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    rst = 1'b1;
    send_byte(8'h77, 1'b0);
    rst = 1'b0;
    chk("mrst_valid", 64'(bus.packed_dataout_valid), 64'd0);
    chk("mrst_prdy",  64'(bus.pack_ready),           64'd1);
    bus.result_datain       = 8'h55;
    bus.result_datain_last  = 1'b1;
    bus.result_datain_valid = 1'b0;
    step();
    bus.result_datain_last  = 1'b0;
    chk("mrst_inv_last", 64'(bus.packed_dataout_valid), 64'd0);
    bus.packed_dataout_ready = 1'b1;
    send_word(8'h31);
    step(3);
    chk("mrst_cnt", 64'(got.size()), 64'd1);
    chk_q("mrst_w0", 0, mk(32'h34333231, 4'hF, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/skintone_result_packer.md
SKINTONE_RESULT_PACKER -- requirements
Module: skintone_result_packer

Interface
REQ-001 Parameter FIFO_DEPTH, default 8; number of 32-bit word entries in the output FIFO; power of two, at least 8.
REQ-002 Parameter ADMIT_THRESH, default 5; minimum free FIFO entries for pack_ready to be high (4 words for 16 results in flight, plus 1 partial word).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 result_datain  input  8  per-pixel skintone result from the datapath.
REQ-006 result_datain_valid  input  1  result_datain is valid this cycle; no backpressure toward the datapath.
REQ-007 result_datain_last  input  1  qualified by valid; marks the final result of a frame.
REQ-008 pack_ready  output  1  upstream may admit a new pixel into the datapath this cycle.
REQ-009 packed_dataout  output  32  packed word; byte i occupies bits [8i+7:8i].
REQ-010 packed_dataout_keep  output  4  bit i set means byte i holds a real result.
REQ-011 packed_dataout_last  output  1  word closes a frame.
REQ-012 packed_dataout_valid  output  1  FIFO head is presented.
REQ-013 packed_dataout_ready  input  1  consumer accepts the head word.
REQ-014 overflow_err  output  1  sticky flag: a packed word was dropped.

Function
REQ-015 A 2-bit byte index (0..3) selects the lane for each valid input byte and advances by 1 per valid byte, wrapping from 3 to 0.
REQ-016 A word is pushed into the FIFO on the clock edge where a valid byte lands in lane 3, or where a valid byte has last=1, whichever comes first.
REQ-017 On a last-triggered push, unfilled lanes are zero, keep shows only the filled lanes (for example 4'b0011 for two bytes), last=1, and the byte index returns to 0.
REQ-018 A push without last carries keep=4'b1111 and last=0.
REQ-019 Latency: a word pushed at edge N into an empty FIFO drives packed_dataout_valid high during the cycle after edge N.
REQ-020 packed_dataout_valid is high exactly when the FIFO is non-empty; the head is held stable while valid is high and ready is low.
REQ-021 A pop occurs on an edge where valid and ready are both high.
REQ-022 When push and pop happen on the same edge, both take effect and the occupancy is unchanged, including when the FIFO is full.
REQ-023 A push into a full FIFO with no simultaneous pop drops the word, leaves the FIFO contents and pointers unchanged, and sets overflow_err until reset.
REQ-024 A pop from an empty FIFO is impossible because valid is low; ready is ignored while the FIFO is empty.
REQ-025 pack_ready = (FIFO_DEPTH - occupancy) >= ADMIT_THRESH, computed combinationally from the registered occupancy.
REQ-026 Pointers wrap modulo FIFO_DEPTH; occupancy is held in a counter of log2(FIFO_DEPTH)+1 bits.
REQ-027 Input bytes with valid=0 are ignored, including their last bit.

Reset
REQ-028 While rst is high at a clock edge, the following are cleared: byte index, partial-word register, FIFO pointers, occupancy and overflow_err.
REQ-029 After reset: packed_dataout_valid=0, packed_dataout_keep=0, packed_dataout_last=0, packed_dataout=0, overflow_err=0 and pack_ready=1.
REQ-030 A reset in the middle of a word or frame discards the partial word and all queued words without emitting them.
REQ-031 Input bytes presented during reset cycles are discarded.

Structure
REQ-032 Shared package skintone_pkg holds the widths PIXEL_W=24, RESULT_W=8 and PACKED_W=32, KEEP_W=4, and DATAPATH_LATENCY=16.
REQ-033 The default ADMIT_THRESH is derived from skintone_pkg as DATAPATH_LATENCY/4 + 1.
REQ-034 Exactly one sub-module is used: skintone_word_fifo, a synchronous FIFO with a 37-bit payload (data, keep, last) that exposes count, full and empty.

Verification
REQ-035 Feed 8 consecutive valid bytes 0x01..0x08 with ready=1 -> two words, 0x04030201 then 0x08070605, each with keep=F and last=0.
REQ-036 Feed 0xAA, 0xBB with last on 0xBB -> one word 0x0000BBAA with keep=3 and last=1; a following 0xCC lands in lane 0.
REQ-037 Hold ready=0 and push 4 words -> pack_ready drops when occupancy reaches 4 (free=4) and returns to 1 when a pop brings occupancy back to 3.
REQ-038 Hold ready=0 and push 9 words -> words 1-8 are retained in order, word 9 is dropped and overflow_err=1; draining yields exactly 8 words.
REQ-039 With the FIFO full, assert ready on the same edge as a push -> occupancy stays 8, overflow_err stays 0, and output order is preserved.
REQ-040 Assert rst after 2 bytes and 3 queued words -> valid=0 on the next cycle, and the next 4 bytes form a fresh word starting at lane 0.
